// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for a 5-stage MIPS pipeline: load-use, ID-branch and
// busy mult/div hazards, plus a saturating stall-cycle performance counter.
module hazard_stall_unit #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6,
  parameter int PERF_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        IF_ID_rs,
  input  logic [4:0]        IF_ID_rt,
  input  logic              IF_ID_UsesRt,
  input  logic              IF_ID_Branch,
  input  logic              IF_ID_UsesHiLo,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic [4:0]        ID_EX_WriteReg,
  input  logic              ID_EX_MulDivStart,
  input  logic              EX_MEM_MemRead,
  input  logic [4:0]        EX_MEM_WriteReg,
  input  logic              BranchTaken,
  input  logic              perf_clear,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              ID_EX_Bubble,
  output logic              IF_ID_Flush,
  output logic              muldiv_busy,
  output logic              muldiv_done,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  perf_q, perf_d;

  logic load_use, br_haz, md_haz, stall, last_busy;

  // $0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic dep(input logic [4:0] r, input logic [4:0] rs,
                               input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    load_use  = ID_EX_MemRead && dep(ID_EX_WriteReg, IF_ID_rs, IF_ID_rt, IF_ID_UsesRt);
    br_haz    = IF_ID_Branch &&
                ((ID_EX_RegWrite && dep(ID_EX_WriteReg, IF_ID_rs, IF_ID_rt, IF_ID_UsesRt)) ||
                 (EX_MEM_MemRead && dep(EX_MEM_WriteReg, IF_ID_rs, IF_ID_rt, IF_ID_UsesRt)));
    md_haz    = IF_ID_UsesHiLo && (ID_EX_MulDivStart || (state_q == BUSY));
    stall     = load_use || br_haz || md_haz;
    last_busy = (state_q == BUSY) && (cnt_q == CNT_ONE);
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    PCWrite      = 1'b0;
    IF_ID_Write  = 1'b0;
    ID_EX_Bubble = 1'b1;
    IF_ID_Flush  = 1'b0;
    muldiv_busy  = 1'b0;
    muldiv_done  = 1'b0;
    if (rst_n) begin
      PCWrite      = !stall;
      IF_ID_Write  = !stall;
      ID_EX_Bubble = stall;
      // A stalled branch compares stale operands, so its outcome is not trusted.
      IF_ID_Flush  = !stall && BranchTaken;
      muldiv_busy  = (state_q == BUSY);
      muldiv_done  = last_busy;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ID_EX_MulDivStart) begin
          state_d = BUSY;
          cnt_d   = RELOAD;
        end
      end
      BUSY: begin
        // A start on the final busy cycle chains straight into the next operation.
        if (last_busy) begin
          if (ID_EX_MulDivStart) begin
            cnt_d = RELOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    perf_d = perf_q;
    if (perf_clear) begin
      perf_d = '0;
    end else if (stall && !(&perf_q)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// scoreboard queue, a negedge monitor pops and compares against the DUT.
module tb_hazard_stall_unit;

  localparam int MD = 4;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_WriteReg, EX_MEM_WriteReg;
  logic IF_ID_UsesRt, IF_ID_Branch, IF_ID_UsesHiLo;
  logic ID_EX_MemRead, ID_EX_RegWrite, ID_EX_MulDivStart, EX_MEM_MemRead;
  logic BranchTaken, perf_clear;
  logic PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, muldiv_busy, muldiv_done;
  logic [PW-1:0] stall_cycles;

  typedef struct {
    string         name;
    logic          pc, ifw, bub, fl, busy, done;
    logic [PW-1:0] sc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULDIV_CYCLES(MD), .CNT_W(6), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .IF_ID_Branch(IF_ID_Branch), .IF_ID_UsesHiLo(IF_ID_UsesHiLo),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_WriteReg(ID_EX_WriteReg), .ID_EX_MulDivStart(ID_EX_MulDivStart),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .BranchTaken(BranchTaken), .perf_clear(perf_clear),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_cycles(stall_cycles)
  );

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (PCWrite === e.pc && IF_ID_Write === e.ifw && ID_EX_Bubble === e.bub &&
          IF_ID_Flush === e.fl && muldiv_busy === e.busy && muldiv_done === e.done &&
          stall_cycles === e.sc) begin
        passes++;
      end else begin
        $display("FAIL %s: got pc=%b ifw=%b bub=%b fl=%b busy=%b done=%b sc=%0d, want pc=%b ifw=%b bub=%b fl=%b busy=%b done=%b sc=%0d",
                 e.name, PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, muldiv_busy,
                 muldiv_done, stall_cycles, e.pc, e.ifw, e.bub, e.fl, e.busy, e.done, e.sc);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(ID_EX_MulDivStart && muldiv_busy && !muldiv_done))
        else $error("illegal mult/div issue while unit busy");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic clear_in();
    IF_ID_rs = 0; IF_ID_rt = 0; IF_ID_UsesRt = 0; IF_ID_Branch = 0; IF_ID_UsesHiLo = 0;
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_WriteReg = 0; ID_EX_MulDivStart = 0;
    EX_MEM_MemRead = 0; EX_MEM_WriteReg = 0; BranchTaken = 0; perf_clear = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  // Forced-reset outputs look exactly like a stall with no flush.
  task automatic exp_v(input string n, input logic st, input logic fl,
                       input logic busy, input logic done, input int sc);
    exp_t e;
    e.name = n; e.pc = !st; e.ifw = !st; e.bub = st; e.fl = fl;
    e.busy = busy; e.done = done; e.sc = PW'(sc);
    sb.push_back(e);
  endtask

  task automatic load_use_vec();
    ID_EX_MemRead = 1; ID_EX_WriteReg = 7; IF_ID_rs = 7;
  endtask

  initial begin
    clear_in();
    rst_n = 0;

    next_cycle(); BranchTaken = 1; IF_ID_UsesHiLo = 1; ID_EX_MulDivStart = 1;
    exp_v("reset_forced", 1, 0, 0, 0, 0);
    next_cycle(); load_use_vec();
    exp_v("reset_hold", 1, 0, 0, 0, 0);
    next_cycle(); rst_n = 1;
    exp_v("idle_after_reset", 0, 0, 0, 0, 0);

    // lw $2 in EX, add $3,$2,$4 in ID
    next_cycle(); ID_EX_MemRead = 1; ID_EX_WriteReg = 2;
    IF_ID_rs = 2; IF_ID_rt = 4; IF_ID_UsesRt = 1;
    exp_v("load_use", 1, 0, 0, 0, 0);
    next_cycle(); ID_EX_MemRead = 1; ID_EX_WriteReg = 0;
    IF_ID_rs = 0; IF_ID_rt = 4; IF_ID_UsesRt = 1;
    exp_v("load_use_r0", 0, 0, 0, 0, 1);
    next_cycle(); ID_EX_MemRead = 1; ID_EX_WriteReg = 2;
    IF_ID_rs = 3; IF_ID_rt = 2; IF_ID_UsesRt = 0;
    exp_v("rt_not_used", 0, 0, 0, 0, 1);
    next_cycle(); IF_ID_Branch = 1; IF_ID_rs = 0; IF_ID_rt = 6; IF_ID_UsesRt = 1;
    ID_EX_RegWrite = 1; ID_EX_WriteReg = 0; BranchTaken = 0;
    exp_v("beq_r0", 0, 0, 0, 0, 1);

    // beq $5,$6 behind a producer of $6
    next_cycle(); IF_ID_Branch = 1; IF_ID_rs = 5; IF_ID_rt = 6; IF_ID_UsesRt = 1;
    ID_EX_RegWrite = 1; ID_EX_WriteReg = 6; BranchTaken = 1;
    exp_v("beq_ex_dep", 1, 0, 0, 0, 1);
    next_cycle(); IF_ID_Branch = 1; IF_ID_rs = 5; IF_ID_rt = 6; IF_ID_UsesRt = 1;
    EX_MEM_MemRead = 1; EX_MEM_WriteReg = 6; BranchTaken = 1;
    exp_v("beq_mem_load", 1, 0, 0, 0, 2);
    next_cycle(); IF_ID_Branch = 1; IF_ID_rs = 5; IF_ID_rt = 6; IF_ID_UsesRt = 1;
    BranchTaken = 1;
    exp_v("beq_taken_flush", 0, 1, 0, 0, 3);
    next_cycle();
    exp_v("idle_1", 0, 0, 0, 0, 3);

    // mult issued in EX with mfhi in ID
    next_cycle(); ID_EX_MulDivStart = 1; IF_ID_UsesHiLo = 1;
    exp_v("md_issue", 1, 0, 0, 0, 3);
    next_cycle(); IF_ID_UsesHiLo = 1; exp_v("md_busy1", 1, 0, 1, 0, 4);
    next_cycle(); IF_ID_UsesHiLo = 1; exp_v("md_busy2", 1, 0, 1, 0, 5);
    next_cycle(); IF_ID_UsesHiLo = 1; exp_v("md_busy3", 1, 0, 1, 0, 6);
    next_cycle(); IF_ID_UsesHiLo = 1; exp_v("md_done", 1, 0, 1, 1, 7);
    next_cycle(); IF_ID_UsesHiLo = 1; exp_v("md_proceed", 0, 0, 0, 0, 8);
    next_cycle(); perf_clear = 1; exp_v("perf_clear", 0, 0, 0, 0, 8);

    // Back-to-back issue on the done cycle
    next_cycle(); ID_EX_MulDivStart = 1; exp_v("b2b_issue", 0, 0, 0, 0, 0);
    next_cycle(); exp_v("b2b_busy1", 0, 0, 1, 0, 0);
    next_cycle(); exp_v("b2b_busy2", 0, 0, 1, 0, 0);
    next_cycle(); exp_v("b2b_busy3", 0, 0, 1, 0, 0);
    next_cycle(); ID_EX_MulDivStart = 1; exp_v("b2b_done_reissue", 0, 0, 1, 1, 0);
    next_cycle(); IF_ID_UsesHiLo = 1; exp_v("b2b_reload1", 1, 0, 1, 0, 0);
    next_cycle(); IF_ID_UsesHiLo = 1; exp_v("b2b_reload2", 1, 0, 1, 0, 1);

    // Reset in the middle of a busy period
    next_cycle(); rst_n = 0; IF_ID_UsesHiLo = 1;
    exp_v("reset_mid_busy", 1, 0, 0, 0, 0);
    next_cycle(); rst_n = 1; IF_ID_UsesHiLo = 1;
    exp_v("mfhi_after_reset", 0, 0, 0, 0, 0);
    next_cycle(); exp_v("idle_2", 0, 0, 0, 0, 0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      next_cycle(); load_use_vec();
      exp_v($sformatf("sat_%0d", i), 1, 0, 0, 0, (i > 15) ? 15 : i);
    end
    next_cycle(); load_use_vec(); perf_clear = 1;
    exp_v("sat_clear_with_stall", 1, 0, 0, 0, 15);
    next_cycle(); load_use_vec();
    exp_v("after_clear", 1, 0, 0, 0, 0);
    next_cycle(); exp_v("count_resumes", 0, 0, 0, 0, 1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
